// File: rtl/filter_loader_pkg.sv
// -----------------------------------------------------------------------------
// filter_loader_pkg
// Shared definitions for the serial filter loader: FSM state encoding,
// default geometry and the number of serial bits that make up one byte.
//
// Build option:
//   PARITY_CHECK_EN - each byte carries a trailing even-parity bit, so a byte
//                     is DATA_W+1 serial bits long instead of DATA_W.
// -----------------------------------------------------------------------------
package filter_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = 3;

`ifdef PARITY_CHECK_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int BITS_PER_BYTE = DEF_DATA_W + PAR_BITS;

endpackage

// File: rtl/filter_loader_ser_deser_byte.sv
// -----------------------------------------------------------------------------
// ser_deser_byte
// Bit shifter plus bit counter. Accepts serial bits MSB first and flags the
// cycle in which the final bit of a byte is being accepted; the completed
// byte is presented combinationally in that same cycle so the parent can
// register it at the accepting edge.
//
// Build option:
//   PARITY_CHECK_EN - a byte is DATA_W data bits followed by one even-parity
//                     bit; par_ok reports whether the 9-bit XOR is zero.
//                     Otherwise par_ok is constant 1.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   clear      drop any partial byte (frame restart)
//   in_valid   ser_in is accepted this cycle
//   ser_in     serial data bit
//   byte_valid final bit of a byte accepted this cycle
//   byte_data  completed byte (valid with byte_valid)
//   par_ok     parity of the completed byte is good (valid with byte_valid)
// -----------------------------------------------------------------------------
module ser_deser_byte
  import filter_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              ser_in,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic              par_ok
);

  localparam int BPB   = DATA_W + PAR_BITS;
  localparam int CNT_W = $clog2(BPB + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BPB - 1);

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              last_bit;

`ifdef PARITY_CHECK_EN
  function automatic logic even_parity_ok(input logic [DATA_W-1:0] d,
                                          input logic              p);
    return ~(^d ^ p);
  endfunction
`endif

  assign last_bit = in_valid && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (in_valid) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
`ifdef PARITY_CHECK_EN
      // The parity bit is checked, not stored.
      if (!last_bit) shreg <= {shreg[DATA_W-2:0], ser_in};
`else
      shreg <= {shreg[DATA_W-2:0], ser_in};
`endif
    end
  end

  always_comb begin
    byte_valid = last_bit;
`ifdef PARITY_CHECK_EN
    byte_data  = shreg;
    par_ok     = even_parity_ok(shreg, ser_in);
`else
    byte_data  = {shreg[DATA_W-2:0], ser_in};
    par_ok     = 1'b1;
`endif
  end

endmodule

// File: rtl/filter_loader.sv
// -----------------------------------------------------------------------------
// filter_loader
// Serial front-end for the median filter. Packs a bit-serial frame into bytes
// and issues one register write (data_out / reg_addr / wr_enable) per byte,
// filling registers 0..NUM_REGS-1, then pulses frame_done. All outputs are
// registered.
//
// Build option:
//   PARITY_CHECK_EN - bytes carry a trailing even-parity bit; bad bytes are
//                     dropped and set the sticky parity_err flag. Without it
//                     parity_err is tied to 0.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   ser_in      serial data bit, MSB first
//   ser_valid   ser_in is sampled this cycle
//   frame_start start / restart a frame (dominates ser_valid)
//   data_out    byte being written          -> filter data_in
//   reg_addr    target register             -> filter reg_addr
//   wr_enable   one-cycle write strobe      -> filter wr_enable
//   busy        frame in progress
//   frame_done  one-cycle frame complete pulse
//   parity_err  sticky parity error flag
// -----------------------------------------------------------------------------
module filter_loader
  import filter_loader_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic              frame_start,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              wr_enable,
  output logic              busy,
  output logic              frame_done,
  output logic              parity_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              shift_en;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              par_ok;
  logic              good_byte;
  logic              last_reg;

  // Next values for the registered outputs.
  logic [DATA_W-1:0] data_d;
  logic [ADDR_W-1:0] addr_d;
  logic              wr_vld_d;
  logic              busy_d;
  logic              done_d;

  logic [DATA_W-1:0] data_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              wr_vld_p1;
  logic              busy_p1;
  logic              done_p1;

  // A restarting frame_start drops the bit offered in the same cycle.
  assign shift_en  = ser_valid && (state_q == ST_SHIFT) && !frame_start;
  assign good_byte = byte_valid && par_ok;
  assign last_reg  = (addr_q == LAST_ADDR);

  ser_deser_byte #(
    .DATA_W(DATA_W)
  ) u_deser (
    .clk       (clk),
    .rst       (rst),
    .clear     (frame_start),
    .in_valid  (shift_en),
    .ser_in    (ser_in),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .par_ok    (par_ok)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    if (frame_start) begin
      state_nxt = ST_SHIFT;
    end else begin
      case (state_q)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_SHIFT: if (good_byte && last_reg) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    wr_vld_d = good_byte;
    data_d   = good_byte ? byte_data : data_p1;
    addr_d   = good_byte ? addr_q    : addr_p1;
    busy_d   = (state_nxt != ST_IDLE);
    // frame_done tracks the DONE state; a restart in DONE still lets it show.
    done_d   = (state_nxt == ST_DONE);
  end

  // Write address: cleared on restart, advanced per accepted byte, and
  // returned to 0 after the last register so it never passes LAST_ADDR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else if (frame_start) begin
      addr_q <= '0;
    end else if (good_byte) begin
      addr_q <= last_reg ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p1   <= '0;
      addr_p1   <= '0;
      wr_vld_p1 <= 1'b0;
      busy_p1   <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      data_p1   <= data_d;
      addr_p1   <= addr_d;
      wr_vld_p1 <= wr_vld_d;
      busy_p1   <= busy_d;
      done_p1   <= done_d;
    end
  end

`ifdef PARITY_CHECK_EN
  logic perr_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       perr_p1 <= 1'b0;
    else if (frame_start)           perr_p1 <= 1'b0;
    else if (byte_valid && !par_ok) perr_p1 <= 1'b1;
  end

  assign parity_err = perr_p1;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_p1;
  assign reg_addr   = addr_p1;
  assign wr_enable  = wr_vld_p1;
  assign busy       = busy_p1;
  assign frame_done = done_p1;

endmodule
